// File: rtl/move_controller.sv
// Connect-four move sequencer: cursor, turn, drop handshake, verdict, blink.
// Sits between the button debouncers and the board/VGA logic.
module move_controller #(
  parameter int N_COLS     = 7,
  parameter int COL_W      = 3,
  parameter int START_COL  = 3,
  parameter int BLINK_CLKS = 12500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       btns,
  output logic             drop_valid,
  input  logic             drop_ready,
  output logic [COL_W-1:0] drop_col,
  output logic             drop_player,
  input  logic             res_valid,
  input  logic             res_full,
  input  logic             res_win,
  input  logic             res_draw,
  output logic [COL_W-1:0] cursor_col,
  output logic             cur_player,
  output logic             cursor_blink,
  output logic             err_full,
  output logic             game_over,
  output logic             winner,
  output logic             is_draw,
  output logic             new_game
);

  localparam int CNT_W =
    (BLINK_CLKS > 1) ? $clog2(BLINK_CLKS) : 1;
  localparam logic [COL_W-1:0] LAST_COL =
    COL_W'(N_COLS - 1);
  localparam logic [COL_W-1:0] START =
    COL_W'(START_COL);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(BLINK_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OVER
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] blink_cnt, blink_cnt_d;
  logic [COL_W-1:0] cursor_col_d, drop_col_d;
  logic             cur_player_d, drop_valid_d;
  logic             drop_player_d, err_full_d;
  logic             game_over_d, winner_d;
  logic             is_draw_d, new_game_d;
  logic             cursor_blink_d, moved;
  logic             left, right, drop;

  assign left  = ~btns[0];
  assign right = ~btns[1];
  assign drop  = ~btns[2];

  always_comb begin
    state_d        = state;
    cursor_col_d   = cursor_col;
    cur_player_d   = cur_player;
    drop_valid_d   = drop_valid;
    drop_col_d     = drop_col;
    drop_player_d  = drop_player;
    err_full_d     = 1'b0;
    game_over_d    = game_over;
    winner_d       = winner;
    is_draw_d      = is_draw;
    new_game_d     = 1'b0;
    moved          = 1'b0;
    blink_cnt_d    = blink_cnt;
    cursor_blink_d = cursor_blink;
    case (state)
      ST_IDLE: begin
        priority case (1'b1)
          drop: begin
            drop_col_d    = cursor_col;
            drop_player_d = cur_player;
            drop_valid_d  = 1'b1;
            state_d       = ST_REQ;
          end
          left & ~right: begin
            cursor_col_d = (cursor_col == '0) ?
              LAST_COL : cursor_col - 1'b1;
            moved = 1'b1;
          end
          right & ~left: begin
            cursor_col_d = (cursor_col == LAST_COL) ?
              '0 : cursor_col + 1'b1;
            moved = 1'b1;
          end
          default: ;
        endcase
      end
      ST_REQ: begin
        if (drop_ready) begin
          drop_valid_d = 1'b0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (res_valid) begin
          if (res_full) begin
            err_full_d = 1'b1;
            state_d    = ST_IDLE;
          end else if (res_win) begin
            game_over_d = 1'b1;
            winner_d    = drop_player;
            state_d     = ST_OVER;
          end else if (res_draw) begin
            game_over_d = 1'b1;
            is_draw_d   = 1'b1;
            state_d     = ST_OVER;
          end else begin
            cur_player_d = ~cur_player;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_OVER: begin
        if (~&btns) begin
          new_game_d   = 1'b1;
          game_over_d  = 1'b0;
          is_draw_d    = 1'b0;
          winner_d     = 1'b0;
          cur_player_d = 1'b0;
          cursor_col_d = START;
          moved        = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A cursor change restarts the blink so the cursor shows at once
    if (moved) begin
      blink_cnt_d    = '0;
      cursor_blink_d = 1'b1;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt_d    = '0;
      cursor_blink_d = ~cursor_blink;
    end else begin
      blink_cnt_d = blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cursor_col   <= START;
      cur_player   <= 1'b0;
      drop_valid   <= 1'b0;
      drop_col     <= '0;
      drop_player  <= 1'b0;
      err_full     <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 1'b0;
      is_draw      <= 1'b0;
      new_game     <= 1'b0;
      cursor_blink <= 1'b1;
      blink_cnt    <= '0;
    end else begin
      state        <= state_d;
      cursor_col   <= cursor_col_d;
      cur_player   <= cur_player_d;
      drop_valid   <= drop_valid_d;
      drop_col     <= drop_col_d;
      drop_player  <= drop_player_d;
      err_full     <= err_full_d;
      game_over    <= game_over_d;
      winner       <= winner_d;
      is_draw      <= is_draw_d;
      new_game     <= new_game_d;
      cursor_blink <= cursor_blink_d;
      blink_cnt    <= blink_cnt_d;
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller with a drop-request scoreboard.
// Runs with a short blink period so blink timing is observable.
module tb_move_controller;

  localparam int COL_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       btns;
  logic             drop_valid;
  logic             drop_ready;
  logic [COL_W-1:0] drop_col;
  logic             drop_player;
  logic             res_valid;
  logic             res_full;
  logic             res_win;
  logic             res_draw;
  logic [COL_W-1:0] cursor_col;
  logic             cur_player;
  logic             cursor_blink;
  logic             err_full;
  logic             game_over;
  logic             winner;
  logic             is_draw;
  logic             new_game;

  int checks   = 0;
  int failures = 0;

  logic [COL_W:0] exp_q[$];

  move_controller #(
    .N_COLS(7),
    .COL_W(COL_W),
    .START_COL(3),
    .BLINK_CLKS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btns(btns),
    .drop_valid(drop_valid),
    .drop_ready(drop_ready),
    .drop_col(drop_col),
    .drop_player(drop_player),
    .res_valid(res_valid),
    .res_full(res_full),
    .res_win(res_win),
    .res_draw(res_draw),
    .cursor_col(cursor_col),
    .cur_player(cur_player),
    .cursor_blink(cursor_blink),
    .err_full(err_full),
    .game_over(game_over),
    .winner(winner),
    .is_draw(is_draw),
    .new_game(new_game)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [2:0] b);
    btns = b;
    step();
    btns = 3'b111;
  endtask

  task automatic verdict(input logic f, input logic w,
                         input logic d);
    res_valid = 1'b1;
    res_full  = f;
    res_win   = w;
    res_draw  = d;
    step();
    res_valid = 1'b0;
    res_full  = 1'b0;
    res_win   = 1'b0;
    res_draw  = 1'b0;
  endtask

  task automatic drop_push(input logic [COL_W-1:0] col,
                           input logic pl);
    press(3'b011);
    exp_q.push_back({pl, col});
    chk("drop_valid_set", 32'(drop_valid), 32'd1);
  endtask

  task automatic xfer();
    logic [COL_W:0] e;
    chk("q_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("xfer_col", 32'(drop_col), 32'(e[COL_W-1:0]));
      chk("xfer_player", 32'(drop_player), 32'(e[COL_W]));
    end
    drop_ready = 1'b1;
    step();
    drop_ready = 1'b0;
    chk("xfer_valid_clr", 32'(drop_valid), 32'd0);
  endtask

  task automatic chk_reset();
    chk("rst_cursor", 32'(cursor_col), 32'd3);
    chk("rst_player", 32'(cur_player), 32'd0);
    chk("rst_dvalid", 32'(drop_valid), 32'd0);
    chk("rst_dcol", 32'(drop_col), 32'd0);
    chk("rst_dplayer", 32'(drop_player), 32'd0);
    chk("rst_err", 32'(err_full), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_draw", 32'(is_draw), 32'd0);
    chk("rst_newgame", 32'(new_game), 32'd0);
    chk("rst_blink", 32'(cursor_blink), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    btns       = 3'b111;
    drop_ready = 1'b0;
    res_valid  = 1'b0;
    res_full   = 1'b0;
    res_win    = 1'b0;
    res_draw   = 1'b0;
    #23;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Blink: period of 4 clocks per half
    steps(3);
    chk("blink_hold", 32'(cursor_blink), 32'd1);
    step();
    chk("blink_tog0", 32'(cursor_blink), 32'd0);
    steps(3);
    chk("blink_hold0", 32'(cursor_blink), 32'd0);
    step();
    chk("blink_tog1", 32'(cursor_blink), 32'd1);
    steps(4);
    chk("blink_pre_mv", 32'(cursor_blink), 32'd0);

    // Cursor moves, with wrap
    press(3'b110);
    chk("left_2", 32'(cursor_col), 32'd2);
    chk("mv_blink", 32'(cursor_blink), 32'd1);
    steps(3);
    chk("mv_cnt_hold", 32'(cursor_blink), 32'd1);
    step();
    chk("mv_cnt_tog", 32'(cursor_blink), 32'd0);
    press(3'b110);
    chk("left_1", 32'(cursor_col), 32'd1);
    press(3'b110);
    chk("left_0", 32'(cursor_col), 32'd0);
    press(3'b110);
    chk("left_wrap", 32'(cursor_col), 32'd6);
    chk("wrap_blink", 32'(cursor_blink), 32'd1);
    press(3'b101);
    chk("right_wrap", 32'(cursor_col), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      press(3'b101);
      chk("right_n", 32'(cursor_col), 32'(i));
    end
    press(3'b100);
    chk("lr_both", 32'(cursor_col), 32'd4);

    // Drop with stalled board, drop beats left in same cycle
    drop_push(3'd4, 1'b0);
    chk("req_col", 32'(drop_col), 32'd4);
    chk("req_player", 32'(drop_player), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) press(3'b110);
      else step();
      chk("stall_valid", 32'(drop_valid), 32'd1);
      chk("stall_col", 32'(drop_col), 32'd4);
      chk("stall_cursor", 32'(cursor_col), 32'd4);
    end
    xfer();
    verdict(1'b0, 1'b0, 1'b0);
    chk("turn_p1", 32'(cur_player), 32'd1);
    chk("turn_cursor", 32'(cursor_col), 32'd4);
    chk("turn_over", 32'(game_over), 32'd0);

    // Rejected move: full has priority over win
    drop_push(3'd4, 1'b1);
    xfer();
    verdict(1'b1, 1'b1, 1'b0);
    chk("full_err", 32'(err_full), 32'd1);
    chk("full_player", 32'(cur_player), 32'd1);
    chk("full_over", 32'(game_over), 32'd0);
    step();
    chk("full_pulse", 32'(err_full), 32'd0);
    press(3'b101);
    chk("full_idle", 32'(cursor_col), 32'd5);

    // Win by player 1, then new game
    drop_push(3'd5, 1'b1);
    xfer();
    verdict(1'b0, 1'b1, 1'b1);
    chk("win_over", 32'(game_over), 32'd1);
    chk("win_who", 32'(winner), 32'd1);
    chk("win_draw", 32'(is_draw), 32'd0);
    verdict(1'b0, 1'b0, 1'b0);
    chk("over_ign_res", 32'(game_over), 32'd1);
    press(3'b011);
    chk("ng_pulse", 32'(new_game), 32'd1);
    chk("ng_over", 32'(game_over), 32'd0);
    chk("ng_winner", 32'(winner), 32'd0);
    chk("ng_player", 32'(cur_player), 32'd0);
    chk("ng_cursor", 32'(cursor_col), 32'd3);
    chk("ng_dvalid", 32'(drop_valid), 32'd0);
    step();
    chk("ng_pulse1", 32'(new_game), 32'd0);

    // Draw by player 0
    drop_push(3'd3, 1'b0);
    xfer();
    verdict(1'b0, 1'b0, 1'b1);
    chk("draw_over", 32'(game_over), 32'd1);
    chk("draw_flag", 32'(is_draw), 32'd1);
    chk("draw_winner", 32'(winner), 32'd0);
    press(3'b110);
    chk("draw_ng", 32'(new_game), 32'd1);
    chk("draw_clr", 32'(is_draw), 32'd0);
    chk("draw_cursor", 32'(cursor_col), 32'd3);

    // Reset during a pending request
    drop_push(3'd3, 1'b0);
    xfer();
    verdict(1'b0, 1'b0, 1'b0);
    chk("pre_rst_p1", 32'(cur_player), 32'd1);
    press(3'b101);
    press(3'b011);
    chk("pre_rst_valid", 32'(drop_valid), 32'd1);
    chk("pre_rst_col", 32'(drop_col), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drop_ready = 1'b1;
    step();
    drop_ready = 1'b0;
    chk("post_rst_valid", 32'(drop_valid), 32'd0);
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
